// File: rtl/mem_arb_pkg.sv
// ============================================================================
//  Module      : mem_arb_pkg
//  Description : Shared types and constants for the memory port arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_arb_pkg;

    // Which requester owns the selection or the pending response
    typedef enum logic [1:0] {
        OWNER_NONE  = 2'd0,
        OWNER_INSTR = 2'd1,
        OWNER_DATA  = 2'd2
    } owner_e;

    // Selection lock: held while the slave stalls a request
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOCK_I = 2'd1,
        LOCK_D = 2'd2
    } lock_state_e;

    localparam int STARVE_CNT_W = 8;

endpackage : mem_arb_pkg

`default_nettype wire

// File: rtl/mem_arb_starve_ctr.sv
// ============================================================================
//  Module      : mem_arb_starve_ctr
//  Description : Counts consecutive data grants while an instruction fetch is
//                waiting; saturates at LIMIT and flags when the limit is hit.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_arb_starve_ctr
    import mem_arb_pkg::*;
#(
    parameter int LIMIT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_instr_req,
    input  logic i_instr_gnt,
    input  logic i_data_gnt,
    output logic o_limit_hit
);

    localparam logic [STARVE_CNT_W-1:0] c_limit = STARVE_CNT_W'(LIMIT);

    logic [STARVE_CNT_W-1:0] r_cnt;

    // Count data grants that overtake a waiting fetch; any fetch grant or an
    // idle fetch side restarts the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (!i_instr_req || i_instr_gnt) begin
            r_cnt <= '0;
        end else if (i_data_gnt && (r_cnt != c_limit)) begin
            r_cnt <= r_cnt + STARVE_CNT_W'(1);
        end
    end

    assign o_limit_hit = (r_cnt == c_limit);

endmodule : mem_arb_starve_ctr

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// ============================================================================
//  Module      : mem_port_arbiter
//  Description : Shares one req/gnt/rvalid memory slave between the fetch and
//                load/store requesters. Fixed priority to data with a
//                starvation guard for fetch; selection is locked while the
//                slave stalls; one-cycle responses are routed to the owner.
//                Optional build macro MEM_PORT_ARBITER_PERF_EN adds grant and
//                conflict performance counters.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    // Instruction fetch requester
    input  logic                instr_req_i,
    input  logic [ADDR_W-1:0]   instr_addr_i,
    output logic                instr_gnt_o,
    output logic                instr_rvalid_o,
    output logic [DATA_W-1:0]   instr_rdata_o,
    // Load/store requester
    input  logic                data_req_i,
    input  logic [ADDR_W-1:0]   data_addr_i,
    input  logic                data_we_i,
    input  logic [DATA_W/8-1:0] data_be_i,
    input  logic [DATA_W-1:0]   data_wdata_i,
    output logic                data_gnt_o,
    output logic                data_rvalid_o,
    output logic [DATA_W-1:0]   data_rdata_o,
    // Shared memory slave
    output logic                mem_valid_o,
    input  logic                mem_ready_i,
    output logic [ADDR_W-1:0]   mem_addr_o,
    output logic                mem_write_en_o,
    output logic [DATA_W/8-1:0] mem_byte_en_o,
    output logic [DATA_W-1:0]   mem_wdata_o,
    input  logic [DATA_W-1:0]   mem_rdata_i
`ifdef MEM_PORT_ARBITER_PERF_EN
    ,
    output logic [31:0]         perf_instr_cnt_o,
    output logic [31:0]         perf_data_cnt_o,
    output logic [31:0]         perf_conflict_cnt_o
`endif
);

    localparam int c_be_w = DATA_W / 8;

    lock_state_e r_lock_state;
    owner_e      r_resp_owner;
    owner_e      w_sel;
    logic        w_mem_valid;
    logic        w_handshake;
    logic        w_instr_gnt;
    logic        w_data_gnt;
    logic        w_limit_hit;

    assign w_mem_valid = instr_req_i | data_req_i;
    assign w_handshake = w_mem_valid & mem_ready_i;

    // Pick the owner of the slave port this cycle; a lock overrides priority
    always_comb begin
        w_sel = OWNER_NONE;
        case (r_lock_state)
            LOCK_I:  w_sel = OWNER_INSTR;
            LOCK_D:  w_sel = OWNER_DATA;
            default: begin
                if (instr_req_i && (!data_req_i || w_limit_hit)) begin
                    w_sel = OWNER_INSTR;
                end else if (data_req_i) begin
                    w_sel = OWNER_DATA;
                end
            end
        endcase
    end

    assign w_instr_gnt = w_handshake & (w_sel == OWNER_INSTR);
    assign w_data_gnt  = w_handshake & (w_sel == OWNER_DATA);

    assign instr_gnt_o = w_instr_gnt;
    assign data_gnt_o  = w_data_gnt;

    // Request path: fetches are always full-word reads
    always_comb begin
        mem_valid_o    = w_mem_valid;
        mem_addr_o     = instr_addr_i;
        mem_write_en_o = 1'b0;
        mem_byte_en_o  = {c_be_w{1'b1}};
        mem_wdata_o    = '0;
        if (w_sel == OWNER_DATA) begin
            mem_addr_o     = data_addr_i;
            mem_write_en_o = data_we_i;
            mem_byte_en_o  = data_be_i;
            mem_wdata_o    = data_wdata_i;
        end
    end

    // Lock FSM plus response-owner tracking for the one-cycle read latency
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lock_state <= IDLE;
            r_resp_owner <= OWNER_NONE;
        end else begin
            r_resp_owner <= w_handshake ? w_sel : OWNER_NONE;
            case (r_lock_state)
                IDLE: begin
                    if (w_mem_valid && !mem_ready_i) begin
                        r_lock_state <= (w_sel == OWNER_DATA) ? LOCK_D : LOCK_I;
                    end
                end
                LOCK_I, LOCK_D: begin
                    if (mem_ready_i) begin
                        r_lock_state <= IDLE;
                    end
                end
                default: r_lock_state <= IDLE;
            endcase
        end
    end

    // Read data is shared; rvalid alone tells each requester it is theirs
    assign instr_rvalid_o = (r_resp_owner == OWNER_INSTR);
    assign data_rvalid_o  = (r_resp_owner == OWNER_DATA);
    assign instr_rdata_o  = mem_rdata_i;
    assign data_rdata_o   = mem_rdata_i;

    mem_arb_starve_ctr #(
        .LIMIT (STARVE_LIMIT)
    ) u_starve_ctr (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_instr_req (instr_req_i),
        .i_instr_gnt (w_instr_gnt),
        .i_data_gnt  (w_data_gnt),
        .o_limit_hit (w_limit_hit)
    );

`ifdef MEM_PORT_ARBITER_PERF_EN
    logic [31:0] r_perf_instr;
    logic [31:0] r_perf_data;
    logic [31:0] r_perf_conflict;

    // Free-running wrap-around event counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_perf_instr    <= '0;
            r_perf_data     <= '0;
            r_perf_conflict <= '0;
        end else begin
            if (w_instr_gnt) begin
                r_perf_instr <= r_perf_instr + 32'd1;
            end
            if (w_data_gnt) begin
                r_perf_data <= r_perf_data + 32'd1;
            end
            if (instr_req_i && data_req_i) begin
                r_perf_conflict <= r_perf_conflict + 32'd1;
            end
        end
    end

    assign perf_instr_cnt_o    = r_perf_instr;
    assign perf_data_cnt_o     = r_perf_data;
    assign perf_conflict_cnt_o = r_perf_conflict;
`endif

endmodule : mem_port_arbiter

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ============================================================================
//  Module      : tb_mem_port_arbiter
//  Description : Directed scoreboard bench for mem_port_arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_port_arbiter;

    logic        clk;
    logic        rst_n;
    logic        instr_req_i;
    logic [31:0] instr_addr_i;
    logic        instr_gnt_o;
    logic        instr_rvalid_o;
    logic [31:0] instr_rdata_o;
    logic        data_req_i;
    logic [31:0] data_addr_i;
    logic        data_we_i;
    logic [3:0]  data_be_i;
    logic [31:0] data_wdata_i;
    logic        data_gnt_o;
    logic        data_rvalid_o;
    logic [31:0] data_rdata_o;
    logic        mem_valid_o;
    logic        mem_ready_i;
    logic [31:0] mem_addr_o;
    logic        mem_write_en_o;
    logic [3:0]  mem_byte_en_o;
    logic [31:0] mem_wdata_o;
    logic [31:0] mem_rdata_i;
`ifdef MEM_PORT_ARBITER_PERF_EN
    logic [31:0] perf_instr_cnt_o;
    logic [31:0] perf_data_cnt_o;
    logic [31:0] perf_conflict_cnt_o;
`endif

    mem_port_arbiter #(
        .ADDR_W       (32),
        .DATA_W       (32),
        .STARVE_LIMIT (4)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .instr_req_i    (instr_req_i),
        .instr_addr_i   (instr_addr_i),
        .instr_gnt_o    (instr_gnt_o),
        .instr_rvalid_o (instr_rvalid_o),
        .instr_rdata_o  (instr_rdata_o),
        .data_req_i     (data_req_i),
        .data_addr_i    (data_addr_i),
        .data_we_i      (data_we_i),
        .data_be_i      (data_be_i),
        .data_wdata_i   (data_wdata_i),
        .data_gnt_o     (data_gnt_o),
        .data_rvalid_o  (data_rvalid_o),
        .data_rdata_o   (data_rdata_o),
        .mem_valid_o    (mem_valid_o),
        .mem_ready_i    (mem_ready_i),
        .mem_addr_o     (mem_addr_o),
        .mem_write_en_o (mem_write_en_o),
        .mem_byte_en_o  (mem_byte_en_o),
        .mem_wdata_o    (mem_wdata_o),
        .mem_rdata_i    (mem_rdata_i)
`ifdef MEM_PORT_ARBITER_PERF_EN
        ,
        .perf_instr_cnt_o    (perf_instr_cnt_o),
        .perf_data_cnt_o     (perf_data_cnt_o),
        .perf_conflict_cnt_o (perf_conflict_cnt_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected transaction: owner 0=none, 1=instr, 2=data
    typedef struct {
        int          own;
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
    } txn_t;

    txn_t exp_q[$];
    txn_t pend;
    txn_t mon_e;
    txn_t mon_nxt;
    int   n_chk  = 0;
    int   n_fail = 0;

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        if (a == 32'h1000_0000) return 32'hDEADBEEF;
        return {a[15:0], ~a[15:0]};
    endfunction

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endfunction

    // Slave model: always ready unless the stimulus says otherwise, data next cycle
    always @(posedge clk) begin
        if (mem_valid_o && mem_ready_i)
            mem_rdata_i <= mem_write_en_o ? 32'h0 : mem_fn(mem_addr_o);
    end

    // Monitor: checks grants against the expected queue and responses one cycle later
    always @(negedge clk) begin
        mon_nxt.own   = 0;
        mon_nxt.addr  = '0;
        mon_nxt.we    = 1'b0;
        mon_nxt.be    = '0;
        mon_nxt.wdata = '0;
        if (!rst_n) begin
            pend = mon_nxt;
        end else begin
            if (pend.own != 0 || instr_rvalid_o || data_rvalid_o) begin
                chk("rvalid", {30'b0, instr_rvalid_o, data_rvalid_o},
                    {30'b0, pend.own == 1, pend.own == 2});
                if (pend.own == 1) chk("instr_rdata", instr_rdata_o, mem_fn(pend.addr));
                if (pend.own == 2 && !pend.we) chk("data_rdata", data_rdata_o, mem_fn(pend.addr));
            end
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                chk("gnt", {30'b0, instr_gnt_o, data_gnt_o},
                    {30'b0, mon_e.own == 1, mon_e.own == 2});
                chk("mem_addr", mem_addr_o, mon_e.addr);
                chk("mem_we", {31'b0, mem_write_en_o}, {31'b0, mon_e.we});
                chk("mem_be", {28'b0, mem_byte_en_o}, {28'b0, mon_e.be});
                if (mon_e.own == 2) chk("mem_wdata", mem_wdata_o, mon_e.wdata);
                mon_nxt = mon_e;
            end else if (instr_gnt_o || data_gnt_o) begin
                chk("spurious_gnt", {30'b0, instr_gnt_o, data_gnt_o}, 32'h0);
            end
            pend = mon_nxt;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic ir, input logic [31:0] ia, input logic dr,
                         input logic [31:0] da, input logic dwe, input logic [3:0] dbe,
                         input logic [31:0] dwd, input logic rdy);
        instr_req_i  = ir;
        instr_addr_i = ia;
        data_req_i   = dr;
        data_addr_i  = da;
        data_we_i    = dwe;
        data_be_i    = dbe;
        data_wdata_i = dwd;
        mem_ready_i  = rdy;
    endtask

    task automatic idle();
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 1'b1);
    endtask

    task automatic push_i(input logic [31:0] a);
        txn_t t;
        t.own = 1; t.addr = a; t.we = 1'b0; t.be = 4'hF; t.wdata = '0;
        exp_q.push_back(t);
    endtask

    task automatic push_d(input logic [31:0] a, input logic we, input logic [3:0] be,
                          input logic [31:0] wd);
        txn_t t;
        t.own = 2; t.addr = a; t.we = we; t.be = be; t.wdata = wd;
        exp_q.push_back(t);
    endtask

    localparam logic [31:0] IA0 = 32'h1000_0000;
    localparam logic [31:0] IA1 = 32'h1000_0004;
    localparam logic [31:0] IA2 = 32'h1000_0008;
    localparam logic [31:0] IA3 = 32'h1000_000C;
    localparam logic [31:0] DA0 = 32'h2000_0000;
    localparam logic [31:0] DA1 = 32'h2000_0010;
    localparam logic [31:0] DA2 = 32'h2000_0020;

    initial begin
        pend.own = 0; pend.addr = '0; pend.we = 1'b0; pend.be = '0; pend.wdata = '0;
        mem_rdata_i = '0;
        rst_n = 1'b0;
        idle();
        repeat (3) cyc();
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_instr_gnt", {31'b0, instr_gnt_o}, 32'h0);
        chk("rst_data_gnt", {31'b0, data_gnt_o}, 32'h0);
        chk("rst_rvalid", {30'b0, instr_rvalid_o, data_rvalid_o}, 32'h0);
        chk("rst_mem_valid", {31'b0, mem_valid_o}, 32'h0);
        cyc();

        // Fetch-only read
        drive(1'b1, IA0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 1'b1);
        push_i(IA0); cyc();
        idle(); cyc(); cyc();

        // Simultaneous requests: data first, then fetch
        drive(1'b1, IA1, 1'b1, DA0, 1'b0, 4'hF, 32'h0, 1'b1);
        push_d(DA0, 1'b0, 4'hF, 32'h0); cyc();
        drive(1'b1, IA1, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 1'b1);
        push_i(IA1); cyc();
        idle(); cyc(); cyc();

        // Data stalled three cycles, fetch arrives mid-stall
        drive(1'b0, 32'h0, 1'b1, DA1, 1'b0, 4'hF, 32'h0, 1'b0); cyc();
        drive(1'b1, IA2, 1'b1, DA1, 1'b0, 4'hF, 32'h0, 1'b0);
        @(negedge clk);
        chk("stall_addr", mem_addr_o, DA1);
        chk("stall_valid", {31'b0, mem_valid_o}, 32'h1);
        @(posedge clk); #1;
        cyc();
        drive(1'b1, IA2, 1'b1, DA1, 1'b0, 4'hF, 32'h0, 1'b1);
        push_d(DA1, 1'b0, 4'hF, 32'h0); cyc();
        drive(1'b1, IA2, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 1'b1);
        push_i(IA2); cyc();
        idle(); cyc(); cyc();

        // Fetch stalled: lock keeps fetch selected even when data shows up
        drive(1'b1, IA3, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 1'b0); cyc();
        drive(1'b1, IA3, 1'b1, DA2, 1'b0, 4'hF, 32'h0, 1'b1);
        push_i(IA3); cyc();
        drive(1'b0, 32'h0, 1'b1, DA2, 1'b0, 4'hF, 32'h0, 1'b1);
        push_d(DA2, 1'b0, 4'hF, 32'h0); cyc();
        idle(); cyc(); cyc();

        // Starvation guard: D,D,D,D,I repeating with both held high
        drive(1'b1, IA3, 1'b1, DA2, 1'b0, 4'hF, 32'h0, 1'b1);
        for (int i = 0; i < 10; i++) begin
            if ((i % 5) == 4) push_i(IA3);
            else push_d(DA2, 1'b0, 4'hF, 32'h0);
            cyc();
        end
        idle(); cyc(); cyc();

        // Partial write
        drive(1'b0, 32'h0, 1'b1, 32'h2000_0044, 1'b1, 4'h3, 32'h0000_1234, 1'b1);
        push_d(32'h2000_0044, 1'b1, 4'h3, 32'h0000_1234); cyc();
        idle(); cyc(); cyc();

        // Reset while a response is pending drops rvalid at once
        drive(1'b1, 32'h1000_0010, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 1'b1);
        push_i(32'h1000_0010); cyc();
        idle();
        #1 rst_n = 1'b0;
        #1;
        chk("rst_drop_instr_rvalid", {31'b0, instr_rvalid_o}, 32'h0);
        chk("rst_drop_data_rvalid", {31'b0, data_rvalid_o}, 32'h0);
        cyc(); cyc();
        rst_n = 1'b1;
        cyc();

        // Reset while a data request is stalled releases the lock
        drive(1'b0, 32'h0, 1'b1, 32'h2000_0050, 1'b0, 4'hF, 32'h0, 1'b0); cyc();
        idle();
        #1 rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        cyc();
        drive(1'b1, 32'h1000_0014, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 1'b1);
        push_i(32'h1000_0014); cyc();
        idle(); cyc(); cyc();

        chk("exp_q_drained", exp_q.size(), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule : tb_mem_port_arbiter

`default_nettype wire

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one MemPort-style memory slave between the core's instruction-fetch and load/store requesters, using the core's req/gnt/rvalid protocol.
- Sits between the RISC-V core wrapper and the single shared SRAM/bus port.
- Fixed-priority arbitration with a starvation guard.
- Locks the selection while a request is stalled and routes the one-cycle-latency response back to the owning requester.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; byte-enable width is DATA_W/8.
- STARVE_LIMIT, 4, consecutive data grants allowed while an instruction request waits; legal range 1..255.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- instr_req_i  in  1  fetch request
- instr_addr_i  in  ADDR_W  fetch address
- instr_gnt_o  out  1  fetch accepted this cycle
- instr_rvalid_o  out  1  fetch response valid
- instr_rdata_o  out  DATA_W  fetch read data
- data_req_i  in  1  LSU request
- data_addr_i  in  ADDR_W  LSU address
- data_we_i  in  1  LSU write enable
- data_be_i  in  DATA_W/8  LSU byte enables
- data_wdata_i  in  DATA_W  LSU write data
- data_gnt_o  out  1  LSU accepted this cycle
- data_rvalid_o  out  1  LSU response valid (reads and writes)
- data_rdata_o  out  DATA_W  LSU read data
- mem_valid_o  out  1  request to slave
- mem_ready_i  in  1  slave accepts; handshake when valid & ready
- mem_addr_o  out  ADDR_W  slave address
- mem_write_en_o  out  1  slave write enable
- mem_byte_en_o  out  DATA_W/8  slave byte enables
- mem_wdata_o  out  DATA_W  slave write data
- mem_rdata_i  in  DATA_W  slave read data, valid the cycle after a handshake

Behaviour:
- Reset (async assert, sync release via clk edge): lock=0, owner=NONE, resp_owner=NONE, starve_cnt=0, all rvalid_o=0, gnt_o=0.
- Datapath: mem_valid_o=instr_req_i|data_req_i; ADDR/WE/BE/WDATA muxed from the selected requester.
- Instruction requests drive write_en=0 and byte_en=all ones.
- Selection when unlocked:
  - data wins if data_req_i, unless starve_cnt==STARVE_LIMIT and instr_req_i, in which case instr wins.
  - Otherwise instr if instr_req_i.
- Lock states: IDLE, LOCK_I, LOCK_D.
  - IDLE -> LOCK_x when mem_valid_o & !mem_ready_i.
  - LOCK_x forces selection x and holds until handshake, then returns to IDLE.
  - Requesters must hold req and payload until gnt (core guarantees this). The arbiter does not re-arbitrate while locked.
- Grant: x_gnt_o = selected(x) & mem_ready_i (combinational, same cycle as handshake). At most one gnt per cycle.
- Response:
  - resp_owner registers the granted requester each handshake cycle, else NONE.
  - x_rvalid_o = (resp_owner==x), exactly 1 cycle after x_gnt_o. This applies to writes too.
  - Both rdata_o are driven from mem_rdata_i unconditionally and qualified only by rvalid.
- Back-to-back: a new handshake is allowed in the same cycle that the previous response is delivered. Throughput is 1 transaction/cycle.
- Starvation counter (8 bits):
  - +1 on each data grant while instr_req_i=1, saturating at STARVE_LIMIT.
  - Cleared on any instr grant, or when instr_req_i=0.
- Simultaneous requests in IDLE with mem_ready_i=1: data granted, instr waits (unless starved).
- Reset mid-operation: any pending rvalid is dropped and the lock is released. Requesters are reset together with the arbiter.
- No combinational path from mem_rdata_i to any mem_* output.

Optional Feature:
- MEM_PORT_ARBITER_PERF_EN defined: adds output ports perf_instr_cnt_o[31:0], perf_data_cnt_o[31:0] and perf_conflict_cnt_o[31:0].
  - Instr/data counters increment on each respective grant.
  - Conflict counter increments each cycle both reqs are high.
  - All wrap at 2^32 and reset to 0.
- Undefined: ports and counters absent; no other behavioural difference.

Decomposition:
- Shared package mem_arb_pkg: enum owner_e {OWNER_NONE, OWNER_INSTR, OWNER_DATA}; enum lock_state_e {IDLE, LOCK_I, LOCK_D}; localparam STARVE_CNT_W=8.
- Sub-module mem_arb_starve_ctr: starvation counter with saturate/clear and a limit_hit output.

Test Plan:
- Instr-only read addr 0x10000000, mem_ready_i=1, mem_rdata_i=0xDEADBEEF next cycle -> instr_gnt_o same cycle, instr_rvalid_o 1 cycle later with rdata 0xDEADBEEF; data_rvalid_o stays 0.
- Both req in the same cycle, ready=1 -> data_gnt_o first, instr_gnt_o next cycle; rvalids follow in order D then I, each 1 cycle after its gnt.
- Data req with ready=0 for 3 cycles, instr_req_i raised in cycle 2 -> mem_addr_o holds the data address, no instr_gnt_o; data granted on ready, then instr granted.
- STARVE_LIMIT=4: data_req_i and instr_req_i held high continuously -> grant pattern D,D,D,D,I repeating; starve_cnt clears after each I.
- Data write we=1, be=0x3, wdata=0x1234 -> mem_write_en_o=1, mem_byte_en_o=0x3; data_rvalid_o pulses 1 cycle after gnt.
- rst_n asserted the cycle after a grant -> rvalid_o forced 0 immediately (async) and lock cleared; after release, the first request is arbitrated normally.
